// File: rtl/ddr3_pattern_read_checker.sv
// ddr3_pattern_read_checker: compares DDR3 read-back beats against a counter-XOR or LFSR pattern
module ddr3_pattern_read_checker #(
  parameter int          DATA_WIDTH     = 64,
  parameter int          NUM_WORDS      = 16777217,
  parameter int          PATTERN_MODE   = 0,
  parameter logic [63:0] SEED           = 64'hdeadfadebabebeef,
  parameter logic [63:0] LFSR_TAPS      = 64'hd800000000000000,
  parameter int          STOP_ON_ERROR  = 1,
  parameter int          ERR_WIDTH      = 16,
  parameter int          TIMEOUT_CYCLES = 0,
  localparam int         IW             = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  avl_rdata_valid,
  input  logic [DATA_WIDTH-1:0] avl_rdata,
  input  logic                  ddr3_init_done,
  input  logic                  ddr3_cal_success,
  input  logic                  ddr3_cal_fail,
  output logic                  is_finished,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic [ERR_WIDTH-1:0]  error_count,
  output logic [IW-1:0]         first_error_index,
  output logic [DATA_WIDTH-1:0] first_error_data
);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [DATA_WIDTH-1:0] SEED_W = DATA_WIDTH'(SEED);
  localparam logic [DATA_WIDTH-1:0] TAPS_W = DATA_WIDTH'(LFSR_TAPS);
  typedef enum logic [1:0] {WAIT_INIT, CHECK, ERROR, DONE} state_t;
  state_t                state_q;
  logic [IW-1:0]         idx_q, fidx_q;
  logic [DATA_WIDTH-1:0] lfsr_q, lfsr_d, fdata_q, exp_w;
  logic [ERR_WIDTH-1:0]  err_q, err_d;
  logic [TW-1:0]         idle_q, idle_d;
  logic                  fin_q, pass_q, fail_q, tmo_q;
  logic                  mism, last, tmo_hit;
  // expected word, mismatch detection, saturating error count and idle timeout
  always_comb begin
    exp_w   = (PATTERN_MODE == 0) ? (SEED_W ^ DATA_WIDTH'(idx_q)) : lfsr_q;
    mism    = avl_rdata_valid && (avl_rdata != exp_w);
    lfsr_d  = {lfsr_q[DATA_WIDTH-2:0], ^(lfsr_q & TAPS_W)};
    err_d   = (mism && err_q != '1) ? err_q + 1'b1 : err_q;
    idle_d  = idle_q + 1'b1;
    last    = idx_q == IW'(NUM_WORDS - 1);
    tmo_hit = (TIMEOUT_CYCLES != 0) && (idle_d == TW'(TIMEOUT_CYCLES));
  end
  // checker FSM; status flags are registered alongside the state transition
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_INIT;
      idx_q   <= '0;
      lfsr_q  <= SEED_W;
      err_q   <= '0;
      idle_q  <= '0;
      fidx_q  <= '0;
      fdata_q <= '0;
      fin_q   <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      case (state_q)
        WAIT_INIT: begin
          if (ddr3_init_done && ddr3_cal_success) begin
            state_q <= CHECK;
          end else if (ddr3_init_done && ddr3_cal_fail) begin
            state_q <= ERROR;
            fin_q   <= 1'b1;
            fail_q  <= 1'b1;
          end
        end
        CHECK: begin
          if (avl_rdata_valid) begin
            idle_q <= '0;
            err_q  <= err_d;
            if (mism && err_q == '0) begin
              fidx_q  <= idx_q;
              fdata_q <= avl_rdata;
            end
            if (mism && STOP_ON_ERROR != 0) begin
              state_q <= ERROR;
              fin_q   <= 1'b1;
              fail_q  <= 1'b1;
            end else begin
              idx_q  <= idx_q + 1'b1;
              lfsr_q <= lfsr_d;
              if (last) begin
                state_q <= DONE;
                fin_q   <= 1'b1;
                pass_q  <= err_d == '0;
                fail_q  <= err_d != '0;
              end
            end
          end else begin
            idle_q <= idle_d;
            if (tmo_hit) begin
              state_q <= ERROR;
              fin_q   <= 1'b1;
              fail_q  <= 1'b1;
              tmo_q   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
  assign is_finished       = fin_q;
  assign pass              = pass_q;
  assign fail              = fail_q;
  assign timeout           = tmo_q;
  assign error_count       = err_q;
  assign first_error_index = fidx_q;
  assign first_error_data  = fdata_q;
endmodule
